angle_step_driver: RTL and testbench

//  Transmit side of the angle step interface: drives the Enable/add_sub pair into the
//  0..360 angle counter so the counter reaches a commanded target angle. Keeps a shadow

---
 rtl/angle_pkg.sv | 20 ++
 rtl/angle_pulse_timer.sv | 33 +++
 rtl/angle_step_driver.sv | 151 +++++++++++++++
 tb/tb_angle_step_driver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/angle_pkg.sv
// Shared constants, state encoding and direction codes for the angle step driver.
package angle_pkg;

  localparam int ANGLE_BITS = 9;
  localparam int ANGLE_W    = ANGLE_BITS + 1;
  localparam int MIN        = 0;
  localparam int MAX        = 360;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DIR  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/angle_pulse_timer.sv
// Loadable down-counter timing the Enable high and low phases; holds at zero.
module angle_pulse_timer #(
  parameter int TW = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  input  logic          count_en_i,
  output logic [TW-1:0] count_o,
  output logic          zero_o
);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_en_i && (count_q != '0)) begin
      count_d = count_q - TW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/angle_step_driver.sv
// Drives Enable/add_sub into the 0..360 angle counter until a shadow copy of the
// counter reaches the commanded target, taking the shortest allowed direction.
module angle_step_driver
  import angle_pkg::*;
#(
  parameter int bits   = ANGLE_BITS,
  parameter int min    = MIN,
  parameter int max    = MAX,
  parameter int HI_CYC = 2,
  parameter int LO_CYC = 2
) (
  input  logic          Clock,
  input  logic          resetn,
  input  logic          go,
  input  logic [bits:0] target,
  input  logic          sync_en,
  input  logic [bits:0] sync_val,
  output logic          Enable,
  output logic          add_sub,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [bits:0] angle
);

  localparam int TMAX = (HI_CYC > LO_CYC) ? HI_CYC : LO_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [bits+1:0] MAX_X = (bits+2)'(max);
  localparam logic [bits+1:0] ONE_X = (bits+2)'(1);
  localparam logic [bits:0]   MAX_A = (bits+1)'(max);
  localparam logic [bits:0]   MIN_A = (bits+1)'(min);
  localparam logic [bits:0]   ONE_A = (bits+1)'(1);
  localparam logic [TW-1:0]   HI_LD = TW'(HI_CYC - 1);
  localparam logic [TW-1:0]   LO_LD = TW'(LO_CYC - 1);

  state_e        state_q, state_d;
  logic [bits:0] angle_q, angle_d;
  logic [bits:0] target_q, target_d;
  logic          dir_q, dir_d;
  logic          err_q, err_d;

  logic          tmr_load, tmr_count, tmr_zero;
  logic [TW-1:0] tmr_val, tmr_cnt;

  logic [bits+1:0] ang_x, tgt_x, in_x, d_dn, d_up;
  logic [bits:0]   step_up, step_dn;

  // Distances are one bit wider than the angle so max+1 never truncates.
  assign ang_x   = {1'b0, angle_q};
  assign tgt_x   = {1'b0, target_q};
  assign in_x    = {1'b0, target};
  assign d_dn    = ang_x - tgt_x;
  assign d_up    = MAX_X + ONE_X - ang_x + tgt_x;
  assign step_up = (angle_q == MAX_A) ? MIN_A : angle_q + ONE_A;
  assign step_dn = angle_q - ONE_A;

  angle_pulse_timer #(.TW(TW)) u_timer (
    .clk_i      (Clock),
    .rst_i      (resetn),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_en_i (tmr_count),
    .count_o    (tmr_cnt),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    angle_d   = angle_q;
    target_d  = target_q;
    dir_d     = dir_q;
    err_d     = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_count = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sync_en) begin
          angle_d = sync_val;
        end else if (go) begin
          if (in_x > MAX_X) begin
            err_d = 1'b1;
          end else begin
            target_d = target;
            state_d  = (target == angle_q) ? DONE : DIR;
          end
        end
      end
      DIR: begin
        // A move crossing min downward would wrap badly in the counter, so
        // any target above the shadow is reached upward; ties go down.
        if (tgt_x > ang_x)      dir_d = DIR_UP;
        else if (d_dn <= d_up)  dir_d = DIR_DN;
        else                    dir_d = DIR_UP;
        state_d  = HI;
        tmr_load = 1'b1;
        tmr_val  = HI_LD;
      end
      HI: begin
        tmr_count = 1'b1;
        if (tmr_cnt == HI_LD) angle_d = dir_q ? step_up : step_dn;
        if (tmr_zero) begin
          state_d  = LO;
          tmr_load = 1'b1;
          tmr_val  = LO_LD;
        end
      end
      LO: begin
        tmr_count = 1'b1;
        if (tmr_zero) begin
          if (angle_q == target_q) begin
            state_d = DONE;
          end else begin
            state_d  = HI;
            tmr_load = 1'b1;
            tmr_val  = HI_LD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (resetn) begin
      state_q <= IDLE;
      angle_q <= MIN_A;
      dir_q   <= DIR_DN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge Clock) begin
    target_q <= target_d;
  end

  assign Enable  = (state_q == HI);
  assign busy    = (state_q == DIR) || (state_q == HI) || (state_q == LO);
  assign done    = (state_q == DONE);
  assign err     = err_q;
  assign add_sub = dir_q;
  assign angle   = angle_q;

endmodule

// File: tb/tb_angle_step_driver.sv
// Bench for angle_step_driver: pairs it with a 0..360 counter and checks every cycle
// against a per-move output timeline built from the stepping rules.
module tb_angle_step_driver;

  localparam int HI = 2;
  localparam int LO = 2;
  localparam int AMAX = 360;

  logic       Clock = 1'b0;
  logic       resetn = 1'b1;
  logic       go = 1'b0;
  logic [9:0] target = '0;
  logic       sync_en = 1'b0;
  logic [9:0] sync_val = '0;
  logic       Enable, add_sub, busy, done, err;
  logic [9:0] angle;

  angle_step_driver dut (
    .Clock    (Clock),
    .resetn   (resetn),
    .go       (go),
    .target   (target),
    .sync_en  (sync_en),
    .sync_val (sync_val),
    .Enable   (Enable),
    .add_sub  (add_sub),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .angle    (angle)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic en, bsy, dn, er, chkd, dir;
    int   ang;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   m_angle = 0;

  // Angle counter: steps once per rising edge of Enable, wraps both ways.
  int   cnt = 0;
  int   npulse = 0;
  logic en_prev = 1'b0;
  logic pre_en = 1'b0;
  int   pre_val = 0;

  always @(posedge Clock) begin
    en_prev <= Enable;
    if (resetn) cnt <= 0;
    else if (pre_en) cnt <= pre_val;
    else if (Enable && !en_prev) begin
      npulse <= npulse + 1;
      if (add_sub) cnt <= (cnt == AMAX) ? 0 : cnt + 1;
      else         cnt <= (cnt == 0) ? AMAX : cnt - 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(logic en, logic bsy, logic dn, logic er, logic chkd,
                              logic dir, int ang);
    exp_t e;
    e.en = en; e.bsy = bsy; e.dn = dn; e.er = er; e.chkd = chkd; e.dir = dir; e.ang = ang;
    return e;
  endfunction

  // Expected output sequence of one accepted command, starting the cycle after go.
  task automatic push_move(input int t);
    int a, up_n, dn_n, n, nxt;
    logic up;
    a = m_angle;
    if (t > AMAX) begin
      q.push_back(mk(0, 0, 0, 1, 0, 0, a));
      return;
    end
    if (t == a) begin
      q.push_back(mk(0, 0, 1, 0, 0, 0, a));
      return;
    end
    up_n = (t - a + AMAX + 1) % (AMAX + 1);
    dn_n = (a - t + AMAX + 1) % (AMAX + 1);
    if (t > a)             begin up = 1'b1; n = up_n; end
    else if (dn_n <= up_n) begin up = 1'b0; n = dn_n; end
    else                   begin up = 1'b1; n = up_n; end
    q.push_back(mk(0, 1, 0, 0, 0, 0, a));
    for (int s = 0; s < n; s++) begin
      nxt = up ? ((a == AMAX) ? 0 : a + 1) : a - 1;
      q.push_back(mk(1, 1, 0, 0, 1, up, a));
      for (int h = 1; h < HI; h++) q.push_back(mk(1, 1, 0, 0, 1, up, nxt));
      for (int l = 0; l < LO; l++) q.push_back(mk(0, 1, 0, 0, 1, up, nxt));
      a = nxt;
    end
    q.push_back(mk(0, 0, 1, 0, 1, up, a));
    m_angle = a;
  endtask

  // Per-cycle compare against the timeline, or against idle outputs when none is pending.
  initial begin
    exp_t e;
    @(posedge Clock);
    forever begin
      @(negedge Clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("enable", int'(Enable), int'(e.en));
        chk("busy", int'(busy), int'(e.bsy));
        chk("done", int'(done), int'(e.dn));
        chk("err", int'(err), int'(e.er));
        chk("angle", int'(angle), e.ang);
        if (e.chkd) chk("add_sub", int'(add_sub), int'(e.dir));
      end else begin
        chk("idle_enable", int'(Enable), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("idle_err", int'(err), 0);
        chk("idle_angle", int'(angle), m_angle);
        chk("idle_counter", cnt, int'(angle));
      end
    end
  end

  task automatic do_go(input int t);
    @(posedge Clock); #1;
    go = 1'b1; target = 10'(t);
    @(posedge Clock);
    push_move(t);
    #1 go = 1'b0;
  endtask

  task automatic do_sync(input int v, input logic with_go, input int t);
    @(posedge Clock); #1;
    sync_en = 1'b1; sync_val = 10'(v); pre_en = 1'b1; pre_val = v;
    go = with_go; target = 10'(t);
    @(posedge Clock);
    m_angle = v;
    #1 sync_en = 1'b0; pre_en = 1'b0; go = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge Clock);
    chk({nm, "_timeout"}, q.size(), 0);
    @(negedge Clock);
  endtask

  initial begin
    int p0;
    repeat (3) @(posedge Clock);
    #1 resetn = 1'b0;
    @(negedge Clock);
    chk("rst_angle", int'(angle), 0);
    chk("rst_enable", int'(Enable), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_add_sub", int'(add_sub), 0);

    // 1: 0 -> 5 upward
    p0 = npulse;
    do_go(5);
    chk("t1_len", q.size(), 1 + 5 * (HI + LO) + 1);
    wait_idle("t1");
    chk("t1_pulses", npulse - p0, 5);
    chk("t1_angle", int'(angle), 5);
    chk("t1_dir", int'(add_sub), 1);

    // 2: 10 -> 3 downward
    do_sync(10, 1'b0, 0);
    p0 = npulse;
    do_go(3);
    wait_idle("t2");
    chk("t2_pulses", npulse - p0, 7);
    chk("t2_angle", int'(angle), 3);
    chk("t2_counter", cnt, 3);
    chk("t2_dir", int'(add_sub), 0);

    // 3: 358 -> 2 upward through the wrap
    do_sync(358, 1'b0, 0);
    p0 = npulse;
    do_go(2);
    wait_idle("t3");
    chk("t3_pulses", npulse - p0, 5);
    chk("t3_angle", int'(angle), 2);
    chk("t3_dir", int'(add_sub), 1);

    // 4: 1 -> 360 must go up; 359 unit steps
    do_sync(1, 1'b0, 0);
    p0 = npulse;
    do_go(360);
    wait_idle("t4");
    chk("t4_pulses", npulse - p0, 359);
    chk("t4_angle", int'(angle), 360);
    chk("t4_counter", cnt, 360);

    // 5: out-of-range targets flag err without motion; go while busy is dropped
    p0 = npulse;
    do_go(400);
    @(negedge Clock);
    do_go(361);
    wait_idle("t5e");
    chk("t5_err_pulses", npulse - p0, 0);
    chk("t5_err_angle", int'(angle), 360);
    p0 = npulse;
    do_go(355);
    repeat (6) @(posedge Clock);
    #1 go = 1'b1; target = 10'd100;
    @(posedge Clock);
    #1 go = 1'b0;
    wait_idle("t5");
    chk("t5_pulses", npulse - p0, 5);
    chk("t5_angle", int'(angle), 355);

    // 6: reset during a HI phase of 0 -> 100, then sync wins over go
    do_sync(0, 1'b0, 0);
    do_go(100);
    repeat (30) @(negedge Clock);
    for (int i = 0; i < 50 && Enable !== 1'b1; i++) @(negedge Clock);
    chk("t6_hi_seen", int'(Enable), 1);
    resetn = 1'b1;
    @(posedge Clock);
    q.delete();
    m_angle = 0;
    #1 resetn = 1'b0;
    @(negedge Clock);
    chk("t6_rst_enable", int'(Enable), 0);
    chk("t6_rst_angle", int'(angle), 0);
    chk("t6_rst_busy", int'(busy), 0);
    do_sync(77, 1'b1, 10);
    @(negedge Clock);
    chk("t6_sync_angle", int'(angle), 77);
    chk("t6_sync_busy", int'(busy), 0);
    p0 = npulse;
    do_go(77);
    wait_idle("t6eq");
    chk("t6_eq_pulses", npulse - p0, 0);
    chk("t6_eq_angle", int'(angle), 77);

    repeat (3) @(negedge Clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
